// File: rtl/rtype_pkg.sv
// Shared types and encodings for the R-type execute sequencer.
package rtype_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_e;

    localparam logic [6:0] OPC_RTYPE       = 7'b0110011;
    localparam logic [6:0] F7_BASE         = 7'b0000000;
    localparam logic [6:0] F7_ALT          = 7'b0100000;
    localparam logic [1:0] ALUOP_LOADSTORE = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE     = 2'b10;

endpackage

// File: rtl/rtype_legal_chk.sv
// Combinational legality check for an RV64 R-type instruction word.
module rtype_legal_chk
    import rtype_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        legal_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct7 = instr_i[31:25];
    assign funct3 = instr_i[14:12];

    // Register specifiers play no part in legality.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // The alternate funct7 is only defined for SUB (000) and SRA (101).
    assign legal_o = (opcode == OPC_RTYPE) &&
                     ((funct7 == F7_BASE) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

endmodule

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle DECODE/EXECUTE/WRITEBACK sequencer for the R-type execute datapath.
// Define RTYPE_BACK2BACK_EN to also accept the next instruction during WRITEBACK.
module rtype_seq_ctrl
    import rtype_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr_in,
    output logic             instr_ready,
    output logic [31:0]      instr_out,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt
);

`ifdef RTYPE_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         exec_cnt_q, exec_cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic               legal_q, legal_d, legal_in;
    logic               ready_q, ready_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               reg_write_q, reg_write_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer;

    assign xfer = instr_valid & ready_q;

    // Legality is evaluated on the incoming word so the verdict is already
    // registered while the FSM sits in DECODE.
    rtype_legal_chk u_legal_chk (
        .instr_i (instr_in),
        .legal_o (legal_in)
    );

    always_comb begin
        state_d    = state_q;
        exec_cnt_d = exec_cnt_q;
        instr_d    = xfer ? instr_in : instr_q;
        legal_d    = xfer ? legal_in : legal_q;

        case (state_q)
            IDLE: begin
                if (xfer) state_d = DECODE;
            end
            DECODE: begin
                if (legal_q) begin
                    state_d    = EXECUTE;
                    exec_cnt_d = EXEC_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            EXECUTE: begin
                if (exec_cnt_q == 4'd0) state_d = WRITEBACK;
                else                    exec_cnt_d = exec_cnt_q - 4'd1;
            end
            WRITEBACK: begin
                state_d = (B2B && xfer) ? DECODE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ready_d     = (state_d == IDLE) || (B2B && (state_d == WRITEBACK));
        busy_d      = (state_d != IDLE);
        alu_op_d    = ((state_d == EXECUTE) || (state_d == WRITEBACK)) ? ALUOP_RTYPE
                                                                       : ALUOP_LOADSTORE;
        done_d      = (state_d == WRITEBACK);
        reg_write_d = done_d && (instr_q[11:7] != 5'd0);
        illegal_d   = xfer && !legal_in;
        cnt_d       = done_d ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            exec_cnt_q  <= 4'd0;
            instr_q     <= 32'd0;
            legal_q     <= 1'b0;
            ready_q     <= 1'b1;
            alu_op_q    <= ALUOP_LOADSTORE;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            exec_cnt_q  <= exec_cnt_d;
            instr_q     <= instr_d;
            legal_q     <= legal_d;
            ready_q     <= ready_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign instr_ready = ready_q;
    assign instr_out   = instr_q;
    assign alu_op      = alu_op_q;
    assign reg_write   = reg_write_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign retire_cnt  = cnt_q;

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Bench for rtype_seq_ctrl: two instances (EXEC_CYCLES=1 and 3) against a transaction-level model.
module tb_rtype_seq_ctrl;

`ifdef RTYPE_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld  [2];
    logic [31:0] ins  [2];
    logic        rdy  [2];
    logic [31:0] iout [2];
    logic [1:0]  aop  [2];
    logic        rw   [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic        ill  [2];
    logic [31:0] cnt  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rtype_seq_ctrl #(.CNT_W(32), .EXEC_CYCLES(1)) u_e1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(vld[0]), .instr_in(ins[0]),
        .instr_ready(rdy[0]), .instr_out(iout[0]), .alu_op(aop[0]), .reg_write(rw[0]),
        .busy(bsy[0]), .done(dn[0]), .illegal(ill[0]), .retire_cnt(cnt[0]));

    rtype_seq_ctrl #(.CNT_W(32), .EXEC_CYCLES(3)) u_e3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(vld[1]), .instr_in(ins[1]),
        .instr_ready(rdy[1]), .instr_out(iout[1]), .alu_op(aop[1]), .reg_write(rw[1]),
        .busy(bsy[1]), .done(dn[1]), .illegal(ill[1]), .retire_cnt(cnt[1]));

    // Reference model: one outstanding transaction per instance, outputs derived
    // from how many edges have passed since it was accepted.
    int          ecount;
    logic        m_has [2];
    int          m_acc [2];
    logic        m_leg [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_cnt [2];
    logic        m_rdy [2];
    logic        e_busy [2];
    logic        e_done [2];
    logic        e_rw   [2];
    logic        e_ill  [2];
    logic [1:0]  e_aop  [2];

    function automatic logic ref_legal(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        if (w[6:0] != 7'h33) return 1'b0;
        if (f7 == 7'h00) return 1'b1;
        return (f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_has[d] = 1'b0; m_acc[d] = 0; m_leg[d] = 1'b0; m_ins[d] = 32'd0;
            m_cnt[d] = 32'd0; m_rdy[d] = 1'b1;
            e_busy[d] = 1'b0; e_done[d] = 1'b0; e_rw[d] = 1'b0; e_ill[d] = 1'b0; e_aop[d] = 2'd0;
        end
    endtask

    task automatic model_step();
        ecount++;
        for (int d = 0; d < 2; d++) begin
            int e, off, last;
            e = (d == 0) ? 1 : 3;
            if (vld[d] && m_rdy[d]) begin
                m_has[d] = 1'b1; m_acc[d] = ecount;
                m_leg[d] = ref_legal(ins[d]); m_ins[d] = ins[d];
            end
            off  = ecount - m_acc[d];
            last = m_leg[d] ? e + 1 : 0;
            e_busy[d] = m_has[d] && (off <= last);
            e_ill[d]  = m_has[d] && !m_leg[d] && (off == 0);
            e_done[d] = m_has[d] && m_leg[d] && (off == e + 1);
            e_rw[d]   = e_done[d] && (m_ins[d][11:7] != 5'd0);
            e_aop[d]  = (m_has[d] && m_leg[d] && off >= 1 && off <= e + 1) ? 2'b10 : 2'b00;
            m_rdy[d]  = !e_busy[d] || (B2B && e_done[d]);
            if (e_done[d]) m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] w);
        @(negedge clk);
        vld[d] = v;
        ins[d] = w;
    endtask

    task automatic test_reset();
        vld[0] = 1'b0; vld[1] = 1'b0; ins[0] = 32'd0; ins[1] = 32'd0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rdy[d] !== 1'b1) begin bad++; $display("FAIL reset_ready d%0d got=%b exp=1", d, rdy[d]); end
            total++;
            if ({bsy[d], aop[d], rw[d], dn[d], ill[d]} !== 6'b0) begin
                bad++; $display("FAIL reset_ctrl d%0d got=%b exp=000000", d, {bsy[d], aop[d], rw[d], dn[d], ill[d]});
            end
            total++;
            if (iout[d] !== 32'd0) begin bad++; $display("FAIL reset_instr d%0d got=%h exp=0", d, iout[d]); end
            total++;
            if (cnt[d] !== 32'd0) begin bad++; $display("FAIL reset_cnt d%0d got=%0d exp=0", d, cnt[d]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int n_alu = 0, n_rw = 0, done_at = -1;
        logic [31:0] c0;
        c0 = cnt[0];
        drive(0, 1'b1, 32'h002081B3);
        tick();
        vld[0] = 1'b0;
        total++;
        if (rdy[0] !== 1'b0) begin bad++; $display("FAIL add_ready_low got=%b exp=0", rdy[0]); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (aop[0] === 2'b10) n_alu++;
            if (rw[0] === 1'b1) n_rw++;
            if (dn[0] === 1'b1 && done_at < 0) done_at = k;
        end
        total++;
        if (n_alu != 2) begin bad++; $display("FAIL add_alu_cycles got=%0d exp=2", n_alu); end
        total++;
        if (n_rw != 1) begin bad++; $display("FAIL add_rw_cycles got=%0d exp=1", n_rw); end
        total++;
        if (done_at != 2) begin bad++; $display("FAIL add_done_edge got=%0d exp=2", done_at); end
        total++;
        if (cnt[0] !== c0 + 32'd1) begin bad++; $display("FAIL add_cnt got=%0d exp=%0d", cnt[0], c0 + 1); end
    endtask

    task automatic test_sub();
        int rw_at = -1, done_at = -1;
        logic held = 1'b1;
        drive(1, 1'b1, 32'h407302B3);
        tick();
        vld[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            ins[1] = $urandom;
            tick();
            if (bsy[1] === 1'b1 && (iout[1] !== 32'h407302B3 || iout[1][30] !== 1'b1)) held = 1'b0;
            if (rw[1] === 1'b1 && rw_at < 0) rw_at = k;
            if (dn[1] === 1'b1 && done_at < 0) done_at = k;
        end
        total++;
        if (rw_at != 4) begin bad++; $display("FAIL sub_rw_edge got=%0d exp=4", rw_at); end
        total++;
        if (done_at != 4) begin bad++; $display("FAIL sub_done_edge got=%0d exp=4", done_at); end
        total++;
        if (held !== 1'b1) begin bad++; $display("FAIL sub_instr_held got=%b exp=1", held); end
    endtask

    task automatic test_illegal();
        logic [31:0] words [2];
        words[0] = 32'h00108093;
        words[1] = 32'h402091B3;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] c0;
            int n_side = 0;
            c0 = cnt[0];
            drive(0, 1'b1, words[i]);
            tick();
            vld[0] = 1'b0;
            total++;
            if (ill[0] !== 1'b1 || bsy[0] !== 1'b1) begin
                bad++; $display("FAIL illegal_pulse w=%h got=%b%b exp=11", words[i], ill[0], bsy[0]);
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                if (ill[0] === 1'b1 || rw[0] === 1'b1 || dn[0] === 1'b1) n_side++;
            end
            total++;
            if (n_side != 0) begin bad++; $display("FAIL illegal_after w=%h got=%0d exp=0", words[i], n_side); end
            total++;
            if (cnt[0] !== c0) begin bad++; $display("FAIL illegal_cnt got=%0d exp=%0d", cnt[0], c0); end
        end
    endtask

    task automatic test_rd0();
        int n_done = 0, n_rw = 0;
        logic [31:0] c0;
        c0 = cnt[0];
        drive(0, 1'b1, 32'h00208033);
        tick();
        vld[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dn[0] === 1'b1) n_done++;
            if (rw[0] === 1'b1) n_rw++;
        end
        total++;
        if (n_done != 1) begin bad++; $display("FAIL rd0_done got=%0d exp=1", n_done); end
        total++;
        if (n_rw != 0) begin bad++; $display("FAIL rd0_rw got=%0d exp=0", n_rw); end
        total++;
        if (cnt[0] !== c0 + 32'd1) begin bad++; $display("FAIL rd0_cnt got=%0d exp=%0d", cnt[0], c0 + 1); end
    endtask

    task automatic test_reset_mid();
        int n_side = 0;
        drive(0, 1'b1, 32'h002081B3);
        tick();
        vld[0] = 1'b0;
        tick();
        total++;
        if (aop[0] !== 2'b10) begin bad++; $display("FAIL mid_in_exec got=%b exp=10", aop[0]); end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({rdy[0], bsy[0], aop[0], rw[0], dn[0], ill[0]} !== 7'b1000000 || iout[0] !== 32'd0 || cnt[0] !== 32'd0) begin
            bad++; $display("FAIL mid_reset_vals got=%b/%h/%0d exp=1000000/0/0",
                            {rdy[0], bsy[0], aop[0], rw[0], dn[0], ill[0]}, iout[0], cnt[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rw[0] === 1'b1 || dn[0] === 1'b1) n_side++;
        end
        total++;
        if (n_side != 0) begin bad++; $display("FAIL mid_after_release got=%0d exp=0", n_side); end
        total++;
        if (cnt[0] !== 32'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", cnt[0]); end
    endtask

    task automatic test_back_to_back();
        int accepted = 0, ndone = 0, exp_gap;
        int dedge [4];
        logic rdy_wb_ok = 1'b1;
        logic [31:0] c0;
        c0 = cnt[0];
        exp_gap = B2B ? 3 : 4;
        drive(0, 1'b1, 32'h002081B3);
        for (int k = 0; k < 40 && ndone < 4; k++) begin
            logic will_accept;
            will_accept = vld[0] && rdy[0];
            tick();
            if (will_accept) begin
                accepted++;
                if (accepted == 4) vld[0] = 1'b0;
            end
            if (dn[0] === 1'b1) begin
                dedge[ndone] = k;
                ndone++;
                if (rdy[0] !== B2B) rdy_wb_ok = 1'b0;
            end
        end
        vld[0] = 1'b0;
        total++;
        if (ndone != 4) begin bad++; $display("FAIL b2b_done_count got=%0d exp=4 (cycle budget)", ndone); end
        for (int i = 1; i < ndone; i++) begin
            total++;
            if (dedge[i] - dedge[i-1] != exp_gap) begin
                bad++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, dedge[i] - dedge[i-1], exp_gap);
            end
        end
        total++;
        if (rdy_wb_ok !== 1'b1) begin bad++; $display("FAIL b2b_ready_wb got=%b exp=1", rdy_wb_ok); end
        total++;
        if (cnt[0] !== c0 + 32'd4) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", cnt[0], c0 + 4); end
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [31:0] r;
                logic [31:0] w;
                r = $urandom;
                case ($urandom_range(0, 4))
                    0: w = r;
                    1: w = {7'h00, r[24:7], 7'h33};
                    2: w = {7'h20, r[24:15], (r[0] ? 3'd5 : 3'd0), r[11:7], 7'h33};
                    3: w = {7'h20, r[24:7], 7'h33};
                    default: w = {7'h00, r[24:12], 5'd0, 7'h33};
                endcase
                vld[d] = ($urandom_range(0, 9) < 6);
                ins[d] = w;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (rdy[d] !== m_rdy[d]) begin bad++; $display("FAIL rnd_ready d%0d n%0d got=%b exp=%b", d, n, rdy[d], m_rdy[d]); end
                total++;
                if (bsy[d] !== e_busy[d]) begin bad++; $display("FAIL rnd_busy d%0d n%0d got=%b exp=%b", d, n, bsy[d], e_busy[d]); end
                total++;
                if (aop[d] !== e_aop[d]) begin bad++; $display("FAIL rnd_aluop d%0d n%0d got=%b exp=%b", d, n, aop[d], e_aop[d]); end
                total++;
                if (rw[d] !== e_rw[d]) begin bad++; $display("FAIL rnd_regwrite d%0d n%0d got=%b exp=%b", d, n, rw[d], e_rw[d]); end
                total++;
                if (dn[d] !== e_done[d]) begin bad++; $display("FAIL rnd_done d%0d n%0d got=%b exp=%b", d, n, dn[d], e_done[d]); end
                total++;
                if (ill[d] !== e_ill[d]) begin bad++; $display("FAIL rnd_illegal d%0d n%0d got=%b exp=%b", d, n, ill[d], e_ill[d]); end
                total++;
                if (iout[d] !== m_ins[d]) begin bad++; $display("FAIL rnd_instr d%0d n%0d got=%h exp=%h", d, n, iout[d], m_ins[d]); end
                total++;
                if (cnt[d] !== m_cnt[d]) begin bad++; $display("FAIL rnd_cnt d%0d n%0d got=%0d exp=%0d", d, n, cnt[d], m_cnt[d]); end
            end
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
    endtask

    initial begin
        ecount = 0;
        test_reset();
        test_add();
        test_sub();
        test_illegal();
        test_rd0();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
